// File: rtl/fft_pair_commutator.sv
// Delay-buffer commutator that pairs x[k] with x[k+DEPTH] for a radix-2 butterfly.
// Optional build macro FFT_PAIR_COMMUTATOR_SCALE_EN halves all pair outputs (>>>1).
module fft_pair_commutator #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] real_in,
    input  logic [DATA_WIDTH-1:0] imag_in,
    output logic                  out_valid,
    output logic                  out_first,
    output logic [DATA_WIDTH-1:0] real_out0,
    output logic [DATA_WIDTH-1:0] imag_out0,
    output logic [DATA_WIDTH-1:0] real_out1,
    output logic [DATA_WIDTH-1:0] imag_out1
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {FILL, PAIR} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] real_buf [DEPTH];
    logic [DATA_WIDTH-1:0] imag_buf [DEPTH];

    logic accept;
    logic idx_last;

    assign accept   = en & in_valid;
    assign idx_last = (idx == IDX_LAST);

    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] v);
`ifdef FFT_PAIR_COMMUTATOR_SCALE_EN
        return {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
`else
        return v;
`endif
    endfunction

    // Buffer is deliberately not reset: every entry is rewritten in FILL before PAIR reads it.
    always_ff @(posedge clk) begin
        if (!rst && accept && state == FILL) begin
            real_buf[idx] <= real_in;
            imag_buf[idx] <= imag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            real_out0 <= '0;
            imag_out0 <= '0;
            real_out1 <= '0;
            imag_out1 <= '0;
        end else if (en) begin
            if (in_valid) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
                if (idx_last) begin
                    state <= (state == FILL) ? PAIR : FILL;
                end
                if (state == PAIR) begin
                    out_valid <= 1'b1;
                    out_first <= (idx == '0);
                    real_out0 <= scale(real_buf[idx]);
                    imag_out0 <= scale(imag_buf[idx]);
                    real_out1 <= scale(real_in);
                    imag_out1 <= scale(imag_in);
                end else begin
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                end
            end else begin
                // Strobes drop on an idle cycle; pair data keeps its last value.
                out_valid <= 1'b0;
                out_first <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_pair_commutator.sv
// Directed self-checking bench for fft_pair_commutator (DEPTH=4, DATA_WIDTH=16).
// Scale expectations follow FFT_PAIR_COMMUTATOR_SCALE_EN when the bench is built with it.
module tb_fft_pair_commutator;

    logic        clk = 1'b0;
    logic        rst, en, in_valid;
    logic [15:0] real_in, imag_in;
    logic        out_valid, out_first;
    logic [15:0] real_out0, imag_out0, real_out1, imag_out1;

    int errors = 0;
    int checks = 0;

    fft_pair_commutator #(
        .DATA_WIDTH(16),
        .DEPTH     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (in_valid),
        .real_in  (real_in),
        .imag_in  (imag_in),
        .out_valid(out_valid),
        .out_first(out_first),
        .real_out0(real_out0),
        .imag_out0(imag_out0),
        .real_out1(real_out1),
        .imag_out1(imag_out1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic f);
        chk({tag, ".valid"}, {15'd0, out_valid}, {15'd0, v});
        chk({tag, ".first"}, {15'd0, out_first}, {15'd0, f});
    endtask

    task automatic chk_pair(input string tag, input logic v, input logic f,
                            input logic [15:0] r0, input logic [15:0] i0,
                            input logic [15:0] r1, input logic [15:0] i1);
        chk_flags(tag, v, f);
        chk({tag, ".r0"}, real_out0, r0);
        chk({tag, ".i0"}, imag_out0, i0);
        chk({tag, ".r1"}, real_out1, r1);
        chk({tag, ".i1"}, imag_out1, i1);
    endtask

    // One clock with the given controls; outputs are settled 1 time unit after the edge.
    task automatic step(input logic e, input logic v, input int r, input int i);
        en       = e;
        in_valid = v;
        real_in  = 16'(r);
        imag_in  = 16'(i);
        @(posedge clk);
        #1;
    endtask

    // Full frame base+1..base+8, imag = -real, with per-sample checks.
    task automatic run_frame(input string tag, input int base);
        for (int s = 1; s <= 8; s++) begin
            step(1'b1, 1'b1, base + s, -(base + s));
            if (s <= 4) begin
                chk_flags($sformatf("%s.fill%0d", tag, s), 1'b0, 1'b0);
            end else begin
                chk_pair($sformatf("%s.pair%0d", tag, s - 5), 1'b1, (s == 5),
                         16'(base + s - 4), 16'(-(base + s - 4)),
                         16'(base + s), 16'(-(base + s)));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        step(1'b1, 1'b1, 0, 0);
        step(1'b1, 1'b1, 0, 0);
        chk_pair("reset", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;

        // Continuous frame, then an idle cycle: strobes drop, data holds.
        run_frame("cont", 0);
        step(1'b1, 1'b0, 0, 0);
        chk_pair("cont.idle", 1'b0, 1'b0, 16'd4, -16'sd4, 16'd8, -16'sd8);

        // Gaps after samples 2 and 6.
        step(1'b1, 1'b1, 1, -1);
        step(1'b1, 1'b1, 2, -2);
        step(1'b1, 1'b0, 77, 77);
        chk_flags("gap.a", 1'b0, 1'b0);
        step(1'b1, 1'b1, 3, -3);
        step(1'b1, 1'b1, 4, -4);
        step(1'b1, 1'b1, 5, -5);
        chk_pair("gap.p0", 1'b1, 1'b1, 16'd1, -16'sd1, 16'd5, -16'sd5);
        step(1'b1, 1'b1, 6, -6);
        chk_pair("gap.p1", 1'b1, 1'b0, 16'd2, -16'sd2, 16'd6, -16'sd6);
        step(1'b1, 1'b0, 88, 88);
        chk_pair("gap.b", 1'b0, 1'b0, 16'd2, -16'sd2, 16'd6, -16'sd6);
        step(1'b1, 1'b1, 7, -7);
        chk_pair("gap.p2", 1'b1, 1'b0, 16'd3, -16'sd3, 16'd7, -16'sd7);
        step(1'b1, 1'b1, 8, -8);
        chk_pair("gap.p3", 1'b1, 1'b0, 16'd4, -16'sd4, 16'd8, -16'sd8);

        // Back-to-back frames with no idle cycle between them.
        run_frame("b2b1", 0);
        run_frame("b2b2", 10);

        // Reset mid-frame after sample 6.
        for (int s = 1; s <= 6; s++) step(1'b1, 1'b1, s, -s);
        chk_pair("prerst", 1'b1, 1'b0, 16'd2, -16'sd2, 16'd6, -16'sd6);
        rst = 1'b1;
        step(1'b1, 1'b1, 99, 99);
        chk_pair("midrst", 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        rst = 1'b0;
        run_frame("postrst", 20);

        // Stall with en=0 while pair (2,6) is presented; in_valid stays high with junk data.
        for (int s = 1; s <= 6; s++) step(1'b1, 1'b1, s, -s);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 500 + c, 500 + c);
            chk_pair($sformatf("stall%0d", c), 1'b1, 1'b0, 16'd2, -16'sd2, 16'd6, -16'sd6);
        end
        step(1'b1, 1'b1, 7, -7);
        chk_pair("stall.p2", 1'b1, 1'b0, 16'd3, -16'sd3, 16'd7, -16'sd7);
        step(1'b1, 1'b1, 8, -8);
        chk_pair("stall.p3", 1'b1, 1'b0, 16'd4, -16'sd4, 16'd8, -16'sd8);

        // Rounding/extreme values; imag mirrors real.
        step(1'b1, 1'b1, 3, 3);
        step(1'b1, 1'b1, -3, -3);
        step(1'b1, 1'b1, 32767, 32767);
        step(1'b1, 1'b1, -32768, -32768);
        step(1'b1, 1'b1, 7, 7);
`ifdef FFT_PAIR_COMMUTATOR_SCALE_EN
        chk_pair("scl0", 1'b1, 1'b1, 16'd1, 16'd1, 16'd3, 16'd3);
        step(1'b1, 1'b1, -7, -7);
        chk_pair("scl1", 1'b1, 1'b0, -16'sd2, -16'sd2, -16'sd4, -16'sd4);
        step(1'b1, 1'b1, 1, 1);
        chk_pair("scl2", 1'b1, 1'b0, 16'd16383, 16'd16383, 16'd0, 16'd0);
        step(1'b1, 1'b1, -1, -1);
        chk_pair("scl3", 1'b1, 1'b0, 16'h C000, 16'h C000, 16'h FFFF, 16'h FFFF);
`else
        chk_pair("scl0", 1'b1, 1'b1, 16'd3, 16'd3, 16'd7, 16'd7);
        step(1'b1, 1'b1, -7, -7);
        chk_pair("scl1", 1'b1, 1'b0, -16'sd3, -16'sd3, -16'sd7, -16'sd7);
        step(1'b1, 1'b1, 1, 1);
        chk_pair("scl2", 1'b1, 1'b0, 16'd32767, 16'd32767, 16'd1, 16'd1);
        step(1'b1, 1'b1, -1, -1);
        chk_pair("scl3", 1'b1, 1'b0, 16'h8000, 16'h8000, 16'h FFFF, 16'h FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
